dmem_arbiter: RTL and testbench

- Two-requester arbiter in front of the single-port data memory.
- Shares the memory between the CPU load/store stage (port C, priority requester) and a DMA/debug loader (port D).
- Drives the memory's addr/data_in/wr_rd inputs (wr_rd: 0 = write, 1 = read) and consumes its data_out.
- Read data is valid in the cycle after the accepting edge; the arbiter tags and routes that response.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_starve_ctr.sv | 39 +++
 rtl/dmem_arbiter.sv | 100 ++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Memory wr_rd encoding, requester ids and the response FSM state encoding.
package dmem_arb_pkg;

    localparam logic MEM_WR = 1'b0;
    localparam logic MEM_RD = 1'b1;

    localparam logic REQ_C = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_C = 2'd1,
        RESP_D = 2'd2
    } resp_state_e;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating starvation counter for the DMA port of dmem_arbiter.
// Only compiled when DMEM_ARB_STARVE_EN is defined.
`ifdef DMEM_ARB_STARVE_EN
module dmem_arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIM);

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU priority, DMA secondary) in front of a single-port data memory.
// Define DMEM_ARB_STARVE_EN to let a starved DMA port pre-empt the CPU after STARVE_LIMIT denials.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  c_req_i,
    input  logic                  c_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] c_addr_i,
    input  logic [DATA_WIDTH-1:0] c_wdata_i,
    output logic                  c_gnt_o,
    output logic                  c_rvalid_o,
    input  logic                  d_req_i,
    input  logic                  d_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_in_o,
    output logic                  mem_wr_rd_o,
    input  logic [DATA_WIDTH-1:0] mem_data_out_i
);

    resp_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  d_prio;

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .inc_i      (d_req_i & ~d_gnt_o),
        .clr_i      (~d_req_i | d_gnt_o),
        .at_limit_o (d_prio)
    );
`else
    assign d_prio = 1'b0;
`endif

    // Grants are gated by reset so nothing can be accepted while it is asserted.
    assign c_gnt_o = rst_ni & c_req_i & ~(d_prio & d_req_i);
    assign d_gnt_o = rst_ni & d_req_i & (~c_req_i | d_prio);

    always_comb begin
        addr_d        = addr_q;
        mem_data_in_o = '0;
        mem_wr_rd_o   = MEM_RD;
        if (c_gnt_o) begin
            addr_d        = c_addr_i;
            mem_data_in_o = c_wdata_i;
            mem_wr_rd_o   = c_wr_rd_i;
        end else if (d_gnt_o) begin
            addr_d        = d_addr_i;
            mem_data_in_o = d_wdata_i;
            mem_wr_rd_o   = d_wr_rd_i;
        end
    end

    assign mem_addr_o = addr_d;
    assign rdata_o    = mem_data_out_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (c_gnt_o && (c_wr_rd_i == MEM_RD)) begin
            state_d = RESP_C;
        end else if (d_gnt_o && (d_wr_rd_i == MEM_RD)) begin
            state_d = RESP_D;
        end
    end

    always_comb begin
        c_rvalid_o = 1'b0;
        d_rvalid_o = 1'b0;
        case (state_q)
            RESP_C:  c_rvalid_o = 1'b1;
            RESP_D:  d_rvalid_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural single-port memory.
// Read responses go through an expected-response queue checked by a separate monitor.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_req = 1'b0, c_wr_rd = 1'b1, d_req = 1'b0, d_wr_rd = 1'b1;
    logic [AW-1:0] c_addr = '0, d_addr = '0;
    logic [DW-1:0] c_wdata = '0, d_wdata = '0;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid, mem_wr_rd;
    logic [DW-1:0] rdata, mem_data_in, mem_dout;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .c_req_i        (c_req),
        .c_wr_rd_i      (c_wr_rd),
        .c_addr_i       (c_addr),
        .c_wdata_i      (c_wdata),
        .c_gnt_o        (c_gnt),
        .c_rvalid_o     (c_rvalid),
        .d_req_i        (d_req),
        .d_wr_rd_i      (d_wr_rd),
        .d_addr_i       (d_addr),
        .d_wdata_i      (d_wdata),
        .d_gnt_o        (d_gnt),
        .d_rvalid_o     (d_rvalid),
        .rdata_o        (rdata),
        .mem_addr_o     (mem_addr),
        .mem_data_in_o  (mem_data_in),
        .mem_wr_rd_o    (mem_wr_rd),
        .mem_data_out_i (mem_dout)
    );

    // Synchronous single-port memory: read data appears the cycle after the edge.
    always @(posedge clk) begin
        if (mem_wr_rd == MEM_WR) mem[mem_addr] <= mem_data_in;
        else                     mem_dout <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (c_rvalid || d_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got c=%0b d=%0b expected none", c_rvalid, d_rvalid);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_port", {30'b0, c_rvalid, d_rvalid}, mon_e.port ? 32'd1 : 32'd2);
                check("resp_data", rdata, mon_e.data);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic xfer(input logic port, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp);
        int  waits = 0;
        bit  got = 0;
        if (port == REQ_C) begin
            c_req = 1'b1; c_wr_rd = wr; c_addr = addr; c_wdata = wdata;
        end else begin
            d_req = 1'b1; d_wr_rd = wr; d_addr = addr; d_wdata = wdata;
        end
        while (!got && waits < 50) begin
            #2;
            if ((port == REQ_C) ? c_gnt : d_gnt) begin
                got = 1;
                check("xfer_mem_wr_rd", {31'b0, mem_wr_rd}, {31'b0, wr});
                check("xfer_mem_addr", {22'b0, mem_addr}, {22'b0, addr});
                if (wr == MEM_WR) check("xfer_mem_data_in", mem_data_in, wdata);
                else              exp_q.push_back('{port: port, data: exp});
            end
            @(posedge clk); #1;
            waits++;
        end
        c_req = 1'b0;
        d_req = 1'b0;
        if (!got) begin
            check("xfer_grant_timeout", 32'd0, 32'd1);
        end else if (wr == MEM_RD) begin
            check("xfer_rvalid", {31'b0, (port == REQ_C) ? c_rvalid : d_rvalid}, 32'd1);
            check("xfer_rdata", rdata, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        xfer(REQ_D, MEM_WR, 10'h010, 32'hDEADBEEF, '0);
        xfer(REQ_D, MEM_WR, 10'h001, 32'h0000000A, '0);
        xfer(REQ_D, MEM_WR, 10'h002, 32'h0000000B, '0);

        // Reset held 3 cycles with both ports trying to write over 0x10.
        rst_n = 1'b0;
        c_req = 1'b1; c_wr_rd = MEM_WR; c_addr = 10'h010; c_wdata = '0;
        d_req = 1'b1; d_wr_rd = MEM_WR; d_addr = 10'h010; d_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("rst_mem_wr_rd", {31'b0, mem_wr_rd}, 32'd1);
            check("rst_c_gnt", {31'b0, c_gnt}, 32'd0);
            check("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
            check("rst_rvalid", {30'b0, c_rvalid, d_rvalid}, 32'd0);
            @(posedge clk); #1;
        end
        c_req = 1'b0;
        d_req = 1'b0;
        rst_n = 1'b1;
        #2;
        check("idle_mem_wr_rd", {31'b0, mem_wr_rd}, 32'd1);
        check("idle_mem_addr_rst", {22'b0, mem_addr}, 32'd0);
        check("idle_mem_data_in", mem_data_in, 32'd0);
        @(posedge clk); #1;
        xfer(REQ_C, MEM_RD, 10'h010, '0, 32'hDEADBEEF);

        // Read-after-write on consecutive edges.
        xfer(REQ_C, MEM_WR, 10'h003, 32'h12345678, '0);
        xfer(REQ_C, MEM_RD, 10'h003, '0, 32'h12345678);
        check("raw_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        #2;
        check("hold_mem_addr", {22'b0, mem_addr}, 32'h3);
        check("hold_mem_wr_rd", {31'b0, mem_wr_rd}, 32'd1);
        check("hold_mem_data_in", mem_data_in, 32'd0);
        @(posedge clk); #1;
        check("rvalid_one_cycle", {31'b0, c_rvalid}, 32'd0);

        // Simultaneous reads: C first, then D.
        c_req = 1'b1; c_wr_rd = MEM_RD; c_addr = 10'h001;
        d_req = 1'b1; d_wr_rd = MEM_RD; d_addr = 10'h002;
        #2;
        check("both_c_gnt", {31'b0, c_gnt}, 32'd1);
        check("both_d_gnt", {31'b0, d_gnt}, 32'd0);
        exp_q.push_back('{port: REQ_C, data: 32'hA});
        @(posedge clk); #1;
        c_req = 1'b0;
        #2;
        check("both_d_gnt_next", {31'b0, d_gnt}, 32'd1);
        check("both_c_rvalid", {31'b0, c_rvalid}, 32'd1);
        exp_q.push_back('{port: REQ_D, data: 32'hB});
        @(posedge clk); #1;
        d_req = 1'b0;
        check("both_d_rvalid", {30'b0, c_rvalid, d_rvalid}, 32'd1);
        check("both_d_rdata", rdata, 32'hB);
        @(posedge clk); #1;

        // CPU hogging the port while DMA waits.
        c_req = 1'b1; c_wr_rd = MEM_RD; c_addr = 10'h001;
        d_req = 1'b1; d_wr_rd = MEM_RD; d_addr = 10'h002;
`ifdef DMEM_ARB_STARVE_EN
        for (int cyc = 1; cyc <= 6; cyc++) begin
            #2;
            check("starve_c_gnt", {31'b0, c_gnt}, (cyc == 5) ? 32'd0 : 32'd1);
            check("starve_d_gnt", {31'b0, d_gnt}, (cyc == 5) ? 32'd1 : 32'd0);
            if (cyc == 5) exp_q.push_back('{port: REQ_D, data: 32'hB});
            else          exp_q.push_back('{port: REQ_C, data: 32'hA});
            @(posedge clk); #1;
            if (cyc == 5) d_req = 1'b0;
        end
        c_req = 1'b0;
`else
        for (int cyc = 1; cyc <= 20; cyc++) begin
            #2;
            check("strict_c_gnt", {31'b0, c_gnt}, 32'd1);
            check("strict_d_gnt", {31'b0, d_gnt}, 32'd0);
            exp_q.push_back('{port: REQ_C, data: 32'hA});
            @(posedge clk); #1;
        end
        c_req = 1'b0;
        #2;
        check("strict_d_gnt_release", {31'b0, d_gnt}, 32'd1);
        exp_q.push_back('{port: REQ_D, data: 32'hB});
        @(posedge clk); #1;
        d_req = 1'b0;
`endif
        @(posedge clk); #1;

        // Reset pulse while a D read response is pending.
        d_req = 1'b1; d_wr_rd = MEM_RD; d_addr = 10'h002;
        #2;
        check("mid_d_gnt", {31'b0, d_gnt}, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        check("mid_d_rvalid_pre", {31'b0, d_rvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_d_rvalid_rst", {31'b0, d_rvalid}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mid_no_resp", {30'b0, c_rvalid, d_rvalid}, 32'd0);
        end
        xfer(REQ_D, MEM_RD, 10'h002, '0, 32'hB);
        xfer(REQ_C, MEM_RD, 10'h003, '0, 32'h12345678);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
